data_demux_router: RTL and testbench
====================================

// Module: data_demux_router
// PURPOSE
//  Parametrised, registered successor to the combinational 32-way data demux in the
//  tp32-to-ICache interconnect. Routes one upstream W-bit stream to NCH downstream
//  channels with valid/ready handshakes, adds a broadcast mode, and drops and counts
//  out-of-range selections. Unselected output slices are driven to zero, so the
//  outputs stay compatible with the downstream wired-OR fabric.
// PARAMETERS
//  NCH   32            number of output channels, >=1
//  W     32            data width, bits
//  SELW  max(1,clog2(NCH))  selection width (derived; do not override)
//  CNTW  16            width of the drop counter
// PORTS
//  clk        in   1        single clock; all logic is on posedge
//  reset      in   1        synchronous reset, active-high
//  enable     in   1        0 = freeze output presentation
//  in_valid   in   1        upstream beat valid
//  in_ready   out  1        upstream may transfer; a transfer is in_valid&in_ready
//  in_data    in   W        payload
//  in_sel     in   SELW     destination channel index
//  in_bcast   in   1        1 = deliver the beat to every channel; in_sel is ignored
//  out_valid  out  NCH      per-channel valid
//  out_ready  in   NCH      per-channel ready
//  out_data   out  NCH*W    slice i = bits [i*W +: W]; zero when out_valid[i]=0
//  drop_pulse out  1        one-cycle pulse for each dropped beat
//  drop_cnt   out  CNTW     saturating count of dropped beats
// BEHAVIOUR
//  - Storage is a 2-entry buffer: head (presented) plus skid. Each entry holds
//    {data, pending[NCH]}. pending = onehot(in_sel), or all-ones when in_bcast=1.
//  - in_ready = !skid_v. It is a registered flag, with no combinational path from
//    out_ready.
//  - Latency: a beat accepted at edge t is presented on out_valid from cycle t+1
//    when head was empty or retires at t. Otherwise it waits in skid.
//  - out_valid[i] = head_v & pending[i] & enable.
//    out_data slice i = out_valid[i] ? head_data : 0.
//  - Per edge: pending <= pending & ~(out_valid & out_ready). The head retires when
//    the next pending is all zero. On retire, skid moves to head in the same edge.
//  - Broadcast completes only once every channel has handshaken. Channels may accept
//    on different cycles, and each channel sees the beat exactly once.
//  - Ordering: beats reach any given channel strictly in acceptance order. The head
//    blocks all channels until it retires (no bypass).
//  - Accept plus retire on the same edge with skid empty: the new beat loads head
//    directly. Full throughput is 1 beat/cycle to a ready channel.
//  - Out-of-range selection (in_bcast=0, in_sel>=NCH):
//    * the beat is consumed (in_ready still governs) but never stored;
//    * drop_pulse=1 for the cycle after acceptance;
//    * drop_cnt increments and sticks at all-ones.
//  - enable=0: no output handshakes occur and pending is frozen. Input acceptance
//    continues until skid is full.
//  - Reset values: head_v=0, skid_v=0, in_ready=0 during reset then 1,
//    out_valid=0, out_data=0, drop_pulse=0, drop_cnt=0.
//  - Reset mid-operation discards both entries with no partial delivery.
//    out_valid=0 on the first cycle after reset.
//  - X/Z on in_sel while in_valid=1 is illegal; assertion-checked in simulation.
//  - NCH=1: in_sel is 1 bit, and in_sel=1 is out-of-range.
// STRUCTURE
//  - Package demux_pkg: function sel_width(nch), entry_t struct {data, pending},
//    and localparam CNT_MAX.
//  - Sub-module demux_skid_buf: the generic 2-entry head/skid buffer with
//    push/pop/full, instantiated once with entry_t.
//  - Top level holds the pending-mask update, per-channel output gating, and the
//    drop counter.
// TESTING
//  1 in_sel=5, data=32'hDEADBEEF, out_ready=all 1 -> out_valid=32'h20 one cycle
//    later; slice5=DEADBEEF, all other slices 0.
//  2 in_bcast=1, data=32'h1234; out_ready bit0 at t1, bit1 at t2, rest at t3 ->
//    each channel sees exactly one valid; head retires at t3; in_ready stays 1.
//  3 Back-to-back beats to ch3 with out_ready[3]=0 -> 2 beats buffered,
//    in_ready=0; release ready -> beats delivered in order, 1/cycle.
//  4 NCH=24, in_sel=30 -> no out_valid, drop_pulse 1 cycle, drop_cnt=1.
//    CNTW=2 with 5 drops -> drop_cnt=3.
//  5 Reset asserted while head=bcast partially delivered and skid full ->
//    out_valid=0 and in_ready=1 after reset; no stale beat appears.
//  6 enable=0 with head valid -> out_valid=0 and no retire;
//    enable=1 -> delivery resumes with pending mask intact.

Source files
------------

// File: rtl/data_demux_router_pkg.sv
// Shared definitions for the data demux router.
//   sel_width(nch) : width of the channel select field (never below 1)
//   DEF_*          : the default interconnect configuration (32 x 32-bit, 16-bit counter)
//   CNT_MAX        : saturation value of the drop counter in the default configuration
//   entry_t        : buffered beat {data, pending} in the default configuration. The
//                    top level declares the same layout sized by its own parameters.
package demux_pkg;

  function automatic int sel_width(input int nch);
    return (nch <= 1) ? 1 : $clog2(nch);
  endfunction

  localparam int DEF_NCH  = 32;
  localparam int DEF_W    = 32;
  localparam int DEF_CNTW = 16;

  localparam logic [DEF_CNTW-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [DEF_W-1:0]   data;
    logic [DEF_NCH-1:0] pending;
  } entry_t;

endpackage

// File: rtl/data_demux_router_if.sv
// Upstream/downstream handshake bundle of the data demux router.
//   in_valid/in_ready/in_data/in_sel/in_bcast : single upstream stream
//   out_valid/out_ready/out_data              : NCH downstream channels, slice i = [i*W +: W]
// master = the side that sources beats and sinks channels; slave = the router.
interface data_demux_router_if
  import demux_pkg::*;
#(
  parameter int NCH = 32,
  parameter int W   = 32
);
  localparam int SELW = sel_width(NCH);

  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      in_data;
  logic [SELW-1:0]   in_sel;
  logic              in_bcast;
  logic [NCH-1:0]    out_valid;
  logic [NCH-1:0]    out_ready;
  logic [NCH*W-1:0]  out_data;

  modport master (
    output in_valid, in_data, in_sel, in_bcast, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_sel, in_bcast, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/data_demux_router_skid_buf.sv
// Generic 2-entry head/skid buffer.
//   clk, reset    : clock, synchronous active-high reset
//   push_i/push_data_i : load a new entry (only honoured while ready_o=1)
//   pop_i         : head retires at this edge; skid (or a concurrent push) refills head
//   head_upd_i    : value written back into head when it stays (e.g. shrinking mask)
//   head_v_o/head_o : presented entry
//   full_o        : skid occupied
//   ready_o       : registered "skid empty" flag, 0 while in reset
module demux_skid_buf
  import demux_pkg::*;
#(
  parameter type T = logic [31:0]
) (
  input  logic clk,
  input  logic reset,
  input  logic push_i,
  input  T     push_data_i,
  input  logic pop_i,
  input  T     head_upd_i,
  output logic head_v_o,
  output T     head_o,
  output logic full_o,
  output logic ready_o
);
  logic head_v_q, head_v_d;
  logic skid_v_q, skid_v_d;
  logic ready_q;
  T     head_q, head_d;
  T     skid_q, skid_d;

  always_comb begin
    head_v_d = head_v_q;
    head_d   = head_q;
    skid_v_d = skid_v_q;
    skid_d   = skid_q;
    if (head_v_q && pop_i) begin
      if (skid_v_q) begin
        head_d   = skid_q;
        skid_v_d = 1'b0;
      end else begin
        // Retire and accept on the same edge: new beat goes straight to head.
        head_v_d = push_i;
        head_d   = push_data_i;
      end
    end else if (head_v_q) begin
      head_d = head_upd_i;
      if (push_i && !skid_v_q) begin
        skid_v_d = 1'b1;
        skid_d   = push_data_i;
      end
    end else if (push_i) begin
      head_v_d = 1'b1;
      head_d   = push_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      ready_q  <= 1'b0;
      head_q   <= '0;
      skid_q   <= '0;
    end else begin
      head_v_q <= head_v_d;
      skid_v_q <= skid_v_d;
      ready_q  <= !skid_v_d;
      head_q   <= head_d;
      skid_q   <= skid_d;
    end
  end

  assign head_v_o = head_v_q;
  assign head_o   = head_q;
  assign full_o   = skid_v_q;
  assign ready_o  = ready_q;
endmodule

// File: rtl/data_demux_router.sv
// Registered 1-to-NCH data demux with valid/ready per channel, broadcast mode and
// out-of-range drop counting.
//   clk, reset  : clock, synchronous active-high reset
//   enable      : 0 freezes output presentation (no handshakes, mask frozen)
//   bus         : slave side of data_demux_router_if (NCH/W must match this module)
//   drop_pulse  : one-cycle pulse per dropped (out-of-range) beat
//   drop_cnt    : saturating count of dropped beats
module data_demux_router
  import demux_pkg::*;
#(
  parameter int NCH  = 32,
  parameter int W    = 32,
  parameter int CNTW = 16,
  localparam int SELW = sel_width(NCH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  data_demux_router_if.slave  bus,
  output logic                drop_pulse,
  output logic [CNTW-1:0]     drop_cnt
);
  typedef struct packed {
    logic [W-1:0]   data;
    logic [NCH-1:0] pending;
  } chan_entry_t;

  // One extra bit so the compare also works when NCH is a power of two.
  localparam logic [SELW:0] NCH_L = (SELW+1)'(NCH);

  logic            xfer, sel_oob, push, pop, full, head_v;
  logic [NCH-1:0]  fire, pend_nxt;
  chan_entry_t     new_ent, head, head_upd;
  logic            drop_pulse_q;
  logic [CNTW-1:0] drop_cnt_q;

  assign xfer    = bus.in_valid & bus.in_ready;
  assign sel_oob = !bus.in_bcast && ({1'b0, bus.in_sel} >= NCH_L);
  assign push    = xfer & !sel_oob;

  assign new_ent.data    = bus.in_data;
  assign new_ent.pending = bus.in_bcast ? {NCH{1'b1}} : (NCH'(1) << bus.in_sel);

  demux_skid_buf #(.T(chan_entry_t)) u_buf (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push),
    .push_data_i(new_ent),
    .pop_i      (pop),
    .head_upd_i (head_upd),
    .head_v_o   (head_v),
    .head_o     (head),
    .full_o     (full),
    .ready_o    (bus.in_ready)
  );

  // Channels already served drop out of the mask; the head retires once it is empty.
  assign bus.out_valid = head.pending & {NCH{head_v & enable}};
  assign fire          = bus.out_valid & bus.out_ready;
  assign pend_nxt      = head.pending & ~fire;
  assign pop           = head_v & ~|pend_nxt;
  assign head_upd.data    = head.data;
  assign head_upd.pending = pend_nxt;

  // Unselected slices are zero so the outputs can feed a wired-OR fabric.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_slice
    assign bus.out_data[gi*W +: W] = bus.out_valid[gi] ? head.data : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_pulse_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      drop_pulse_q <= xfer & sel_oob;
      if (xfer && sel_oob && (drop_cnt_q != {CNTW{1'b1}})) begin
        drop_cnt_q <= drop_cnt_q + 1'b1;
      end
    end
  end

  assign drop_pulse = drop_pulse_q;
  assign drop_cnt   = drop_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (bus.in_valid) begin
        assert (!$isunknown(bus.in_sel));
      end
      assert (!(push && full));
    end
  end
endmodule

// File: tb/tb_data_demux_router.sv
// Scoreboard bench for data_demux_router: per-channel expected queues are filled when
// a beat is accepted and drained by a negedge monitor as channels handshake.
module tb_data_demux_router;
  import demux_pkg::*;

  localparam int NCH    = 32;
  localparam int W      = 32;
  localparam int CNTW   = 16;
  localparam int NCH_B  = 24;
  localparam int CNTW_B = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;
  logic enable_b = 1'b1;
  logic drop_pulse, drop_pulse_b;
  logic [CNTW-1:0]   drop_cnt;
  logic [CNTW_B-1:0] drop_cnt_b;

  data_demux_router_if #(.NCH(NCH),   .W(W)) bus_a ();
  data_demux_router_if #(.NCH(NCH_B), .W(W)) bus_b ();

  data_demux_router #(.NCH(NCH), .W(W), .CNTW(CNTW)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .bus(bus_a),
    .drop_pulse(drop_pulse), .drop_cnt(drop_cnt)
  );

  data_demux_router #(.NCH(NCH_B), .W(W), .CNTW(CNTW_B)) dut_b (
    .clk(clk), .reset(reset), .enable(enable_b), .bus(bus_b),
    .drop_pulse(drop_pulse_b), .drop_cnt(drop_cnt_b)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit rand_ready = 1'b0;
  logic [W-1:0] exp_q [NCH][$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) bus_a.out_ready = $urandom | $urandom | $urandom;
  endtask

  function automatic int pending_total();
    int s = 0;
    for (int i = 0; i < NCH; i++) s += exp_q[i].size();
    return s;
  endfunction

  // Present one beat to dut_a and hold it until accepted (bounded).
  task automatic send_a(input int sel, input bit bcast, input logic [W-1:0] data);
    int waited = 0;
    bus_a.in_valid = 1'b1;
    bus_a.in_sel   = 5'(sel);
    bus_a.in_bcast = bcast;
    bus_a.in_data  = data;
    while (!bus_a.in_ready && waited < 60) begin
      step();
      waited++;
    end
    if (!bus_a.in_ready) begin
      check("accept_timeout", 64'(bus_a.in_ready), 64'd1);
    end else begin
      if (bcast) for (int i = 0; i < NCH; i++) exp_q[i].push_back(data);
      else       exp_q[sel].push_back(data);
      $display("send sel=%0d bcast=%0d data=%h", sel, bcast, data);
    end
    step();
    bus_a.in_valid = 1'b0;
  endtask

  // Monitor: every valid slice must match the head of that channel's queue; idle slices are 0.
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        logic [W-1:0] sl;
        sl = bus_a.out_data[i*W +: W];
        if (bus_a.out_valid[i]) begin
          if (exp_q[i].size() == 0) begin
            check("stray_beat_queue_depth", 64'(exp_q[i].size()), 64'd1);
          end else begin
            check("ch_data", 64'(sl), 64'(exp_q[i][0]));
            if (bus_a.out_ready[i]) begin
              void'(exp_q[i].pop_front());
              $display("deliver ch=%0d data=%h", i, sl);
            end
          end
        end else begin
          check("ch_idle_zero", 64'(sl), 64'd0);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NCH*W-1:0] tmp;
    bus_a.in_valid = 0; bus_a.in_sel = '0; bus_a.in_bcast = 0; bus_a.in_data = '0;
    bus_a.out_ready = '0;
    bus_b.in_valid = 0; bus_b.in_sel = '0; bus_b.in_bcast = 0; bus_b.in_data = '0;
    bus_b.out_ready = '1;

    // Reset state
    repeat (3) step();
    check("rst_in_ready", 64'(bus_a.in_ready), 0);
    check("rst_out_valid", 64'(bus_a.out_valid), 0);
    check("rst_out_data_any", 64'(|bus_a.out_data), 0);
    check("rst_drop_pulse", 64'(drop_pulse), 0);
    check("rst_drop_cnt", 64'(drop_cnt), 0);
    reset = 1'b0;
    step();
    step();
    check("post_rst_in_ready", 64'(bus_a.in_ready), 1);

    // 1: single beat to ch5
    bus_a.out_ready = '1;
    send_a(5, 0, 32'hDEADBEEF);
    check("t1_out_valid", 64'(bus_a.out_valid), 64'h20);
    check("t1_slice5", 64'(bus_a.out_data[5*W +: W]), 64'hDEADBEEF);
    tmp = bus_a.out_data;
    tmp[5*W +: W] = '0;
    check("t1_other_slices", 64'(|tmp), 0);
    step();
    check("t1_retired", 64'(bus_a.out_valid), 0);

    // Full-rate burst to a ready channel: never stalls
    for (int k = 0; k < 4; k++) begin
      check("burst_in_ready", 64'(bus_a.in_ready), 1);
      send_a(1, 0, 32'hB0000000 + 32'(k));
    end
    step();

    // 2: broadcast with staggered channel readiness
    bus_a.out_ready = '0;
    send_a(0, 1, 32'h1234);
    check("t2_all_valid", 64'(bus_a.out_valid), 64'hFFFFFFFF);
    bus_a.out_ready = 32'h1;
    step();
    check("t2_after_t1", 64'(bus_a.out_valid), 64'hFFFFFFFE);
    check("t2_in_ready_t1", 64'(bus_a.in_ready), 1);
    bus_a.out_ready = 32'h2;
    step();
    check("t2_after_t2", 64'(bus_a.out_valid), 64'hFFFFFFFC);
    bus_a.out_ready = 32'hFFFFFFFC;
    step();
    check("t2_retired", 64'(bus_a.out_valid), 0);
    check("t2_in_ready_t3", 64'(bus_a.in_ready), 1);
    check("t2_queues_empty", 64'(pending_total()), 0);

    // 3: two beats to a stalled ch3 fill head+skid
    bus_a.out_ready = '0;
    send_a(3, 0, 32'hA1);
    send_a(3, 0, 32'hA2);
    check("t3_in_ready_full", 64'(bus_a.in_ready), 0);
    check("t3_out_valid", 64'(bus_a.out_valid), 64'h8);
    bus_a.out_ready = 32'h8;
    step();
    check("t3_second_presented", 64'(bus_a.out_data[3*W +: W]), 64'hA2);
    check("t3_in_ready_free", 64'(bus_a.in_ready), 1);
    step();
    check("t3_drained", 64'(bus_a.out_valid), 0);

    // Random traffic against random per-channel readiness
    rand_ready = 1'b1;
    for (int k = 0; k < 60; k++) begin
      send_a($urandom_range(0, NCH-1), ($urandom_range(0, 7) == 0), $urandom);
    end
    rand_ready = 1'b0;
    bus_a.out_ready = '1;
    repeat (6) step();
    check("rand_queues_empty", 64'(pending_total()), 0);

    // 6: enable=0 freezes a partially delivered broadcast
    bus_a.out_ready = '0;
    send_a(0, 1, 32'hCAFE);
    bus_a.out_ready = 32'h1;
    step();
    enable = 1'b0;
    bus_a.out_ready = '1;
    #1;
    check("t6_frozen_valid", 64'(bus_a.out_valid), 0);
    step();
    step();
    check("t6_still_frozen", 64'(bus_a.out_valid), 0);
    enable = 1'b1;
    #1;
    check("t6_mask_intact", 64'(bus_a.out_valid), 64'hFFFFFFFE);
    step();
    check("t6_retired", 64'(bus_a.out_valid), 0);
    check("t6_queues_empty", 64'(pending_total()), 0);

    // 4: NCH=24 out-of-range selections, 2-bit saturating counter
    check("t4_in_ready", 64'(bus_b.in_ready), 1);
    bus_b.in_valid = 1'b1;
    bus_b.in_sel = 5'd30;
    bus_b.in_data = 32'h5555;
    step();
    bus_b.in_valid = 1'b0;
    check("t4_no_valid", 64'(bus_b.out_valid), 0);
    check("t4_drop_pulse", 64'(drop_pulse_b), 1);
    check("t4_drop_cnt1", 64'(drop_cnt_b), 1);
    step();
    check("t4_pulse_end", 64'(drop_pulse_b), 0);
    bus_b.in_valid = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      step();
      check("t4_drop_cnt_sat", 64'(drop_cnt_b), 64'((k < 3) ? k : 3));
    end
    bus_b.in_valid = 1'b0;
    bus_b.in_sel = 5'd23;
    bus_b.in_data = 32'h7777;
    bus_b.in_valid = 1'b1;
    step();
    bus_b.in_valid = 1'b0;
    check("t4_ch23_valid", 64'(bus_b.out_valid), 64'h800000);
    check("t4_ch23_data", 64'(bus_b.out_data[23*W +: W]), 64'h7777);
    step();
    check("t4_ch23_retired", 64'(bus_b.out_valid), 0);

    // 5: reset with a partial broadcast in head and a full skid
    bus_a.out_ready = '0;
    send_a(0, 1, 32'hBC00);
    bus_a.out_ready = 32'h1;
    step();
    bus_a.out_ready = '0;
    send_a(2, 0, 32'hBC01);
    check("t5_skid_full", 64'(bus_a.in_ready), 0);
    reset = 1'b1;
    for (int i = 0; i < NCH; i++) exp_q[i].delete();
    step();
    check("t5_rst_in_ready", 64'(bus_a.in_ready), 0);
    check("t5_rst_out_valid", 64'(bus_a.out_valid), 0);
    bus_a.out_ready = '1;
    reset = 1'b0;
    step();
    check("t5_first_cycle_valid", 64'(bus_a.out_valid), 0);
    check("t5_in_ready", 64'(bus_a.in_ready), 1);
    check("t5_drop_cnt_b_cleared", 64'(drop_cnt_b), 0);
    step();
    check("t5_no_stale", 64'(bus_a.out_valid), 0);
    send_a(9, 0, 32'h9999);
    check("t5_fresh_beat", 64'(bus_a.out_valid), 64'h200);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
